iob_aclint: RTL
===============

# iob_aclint

Parametrised core-local interruptor serving `N_HARTS` harts from one shared real-time counter. It generates per-hart machine-timer (`mtip`) and machine-software (`msip`) interrupt lines. Each hart gets a one-shot or auto-reload periodic timer mode, and the block supports tear-free 64-bit `mtime` reads over the 32-bit native bus. It sits on the SoC peripheral bus next to the cores and replaces the fixed single-mode CLINT.

## Interface
- `N_HARTS`, 1: number of harts; legal range 1..64.
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 32: bus data width; only 32 is supported.
- `MTIME_W`, 64: implemented counter width, 32..64. Bits at or above `MTIME_W` read 0 and ignore writes.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `rtc`  in  1  real-time clock, asynchronous to `clk` and slower than `clk`/4.
- `valid`  in  1  request strobe.
- `address`  in  `ADDR_W`  byte address, word aligned.
- `wdata`  in  `DATA_W`  write data.
- `wstrb`  in  `DATA_W/8`  byte write enables; 0 means read.
- `rdata`  out  `DATA_W`  read data, qualified by `ready`.
- `ready`  out  1  one-cycle response pulse.
- `mtip`  out  `N_HARTS`  timer interrupt, one bit per hart.
- `msip`  out  `N_HARTS`  software interrupt, one bit per hart.

## Operation
Register map (h = hart index):
- `MSIP`: 0x0000 + 4h. Bit 0 drives `msip[h]`.
- `MTIMECMP` lo/hi: 0x4000 + 8h, and +4.
- `CTRL`: 0x8000 + 16h.
  - bit0 PERIODIC.
  - bit1 PENDING (write 1 to clear; writing 0 has no effect).
- `PERIOD` lo/hi: 0x8004 + 16h, and +8.
- `MTIME` lo/hi: 0xBFF8 and 0xBFFC.

Bus and access rules:
- Byte writes honour `wstrb`.
- Unmapped addresses, and hart index ≥ `N_HARTS`, complete normally: `ready` is asserted, `rdata` = 0, writes are dropped.

Counter and `rtc` handling:
- `rtc` passes through a 2-FF synchroniser, then a rising-edge detector, producing `tick`.
- On each `tick`, `mtime` increments by 1 and wraps from 2^`MTIME_W`−1 to 0.
- A bus write to `MTIME` in the same cycle as `tick` wins: the written value is loaded and that increment is lost.

Tear-free `mtime` read:
- Reading `MTIME` lo returns the live low word and latches the live high word into a shadow register.
- Reading `MTIME` hi returns the shadow, not the live high word.

Timer modes:
- One-shot (PERIODIC = 0): `mtip[h]` is the registered value of (`mtime` ≥ `mtimecmp[h]`), unsigned compare. PENDING is not used.
- Periodic (PERIODIC = 1), on the cycle the compare is true:
  - PENDING is set.
  - If `PERIOD` ≠ 0, `mtimecmp[h]` += `PERIOD` (modulo 2^`MTIME_W`).
  - `mtip[h]` = PENDING, and stays high until software clears it.
  - If `PERIOD` = 0, `mtimecmp` is unchanged, so PENDING re-sets on the next cycle after a clear.

Simultaneous events:
- A bus write to `MTIMECMP[h]` in the same cycle as an auto-reload: the bus write wins.
- A PENDING clear in the same cycle as a set: the set wins.

Reset values (`rst` = 0 sampled on `clk`):
- `mtime`, `MSIP`, `CTRL`, `PERIOD`, shadow = 0.
- `mtimecmp` = all ones.
- `mtip` = 0, `msip` = 0, `ready` = 0, `rdata` = 0.
- Synchroniser flops = 0, so no `tick` is generated from reset.
- A reset asserted mid-transaction aborts the access; no `ready` pulse is issued.

## Timing
- `valid` sampled high at edge N produces `ready` = 1 for exactly one cycle after edge N+1, with `rdata` valid in that cycle.
- A write takes effect at edge N: the register shows the new value from N+1. `msip` updates at N+1.
- Back-to-back requests are accepted every cycle.
- `rtc` rising edge to `mtime` increment: 3 `clk` edges (2 synchroniser edges + 1 edge-detect edge).
- `mtime`/`mtimecmp` change to `mtip` change: 1 `clk`.
- Periodic reload is applied at the same edge that sets PENDING.

## Structure
- Package `iob_aclint_pkg` holds:
  - the offsets `MSIP_BASE`, `MTIMECMP_BASE`, `CTRL_BASE`, `MTIME_BASE`;
  - the per-hart strides 4, 8 and 16;
  - the CTRL bit indices.
- Sub-module `iob_aclint_rtc_sync`: synchroniser plus edge detector, outputting `tick`.
- Per-hart compare/reload logic is a generate loop inside the top module, not a separate module.

## Test plan
- **Reset:** hold `rst` = 0 for 5 cycles. `mtip` = `msip` = 0, `MTIMECMP0` reads 0xFFFFFFFF/0xFFFFFFFF, `MTIME` reads 0.
- **One-shot:** write `MTIMECMP0` = 20/0. `mtip[0]` rises 1 `clk` after `mtime` reaches 20. Writing `MTIMECMP0` = 100 drops it next cycle.
- **Periodic:** set `CTRL1` = 1, `PERIOD1` = 10, `MTIMECMP1` = 5. PENDING sets at `mtime` = 5 and `MTIMECMP1` becomes 15. After a W1C clear, `mtip[1]` re-asserts at `mtime` = 15.
- **Software interrupt:** write `MSIP[N_HARTS-1]` = 1. Only that `msip` bit rises, 1 cycle after the write. Writing 0 clears it.
- **Tear-free read:** preload `MTIME` = 0x0000_0000_FFFF_FFFE, then read lo, wait for 3 ticks, read hi. The bench gets 0xFFFFFFFE / 0x00000000 (shadow hi, not the live 1). Check wrap at `MTIME_W` = 40.
- **Collisions:** write `MTIME` on a `tick` cycle; the written value holds with no +1. An access to unmapped 0x2000 returns `ready` with `rdata` = 0.

Source files
------------

// File: rtl/iob_aclint_pkg.sv
// iob_aclint shared definitions: register map offsets, per-hart strides,
// CTRL bit positions, register-select encoding and a byte-lane write helper.
package iob_aclint_pkg;

    // Region base offsets
    localparam logic [31:0] MSIP_BASE       = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_BASE   = 32'h0000_4000;
    localparam logic [31:0] CTRL_BASE       = 32'h0000_8000;
    localparam logic [31:0] MTIME_BASE      = 32'h0000_BFF8;

    // Per-hart strides inside each region
    localparam logic [31:0] MSIP_STRIDE     = 32'd4;
    localparam logic [31:0] MTIMECMP_STRIDE = 32'd8;
    localparam logic [31:0] CTRL_STRIDE     = 32'd16;

    // Word slots inside one CTRL stride
    localparam logic [1:0] CTRL_WORD      = 2'd0;
    localparam logic [1:0] PERIOD_LO_WORD = 2'd1;
    localparam logic [1:0] PERIOD_HI_WORD = 2'd2;

    // CTRL bit indices
    localparam int CTRL_PERIODIC_BIT = 0;
    localparam int CTRL_PENDING_BIT  = 1;

    typedef enum logic [3:0] {
        REG_NONE     = 4'd0,
        REG_MSIP     = 4'd1,
        REG_CMP_LO   = 4'd2,
        REG_CMP_HI   = 4'd3,
        REG_CTRL     = 4'd4,
        REG_PER_LO   = 4'd5,
        REG_PER_HI   = 4'd6,
        REG_MTIME_LO = 4'd7,
        REG_MTIME_HI = 4'd8
    } reg_sel_e;

    // Merge a 32-bit bus write into the low or high word of a 64-bit value,
    // honouring the byte strobes. Callers truncate to their implemented width,
    // which is how bits above MTIME_W ignore writes.
    function automatic logic [63:0] write_word(input logic [63:0] old_v,
                                               input logic        hi,
                                               input logic [31:0] wd,
                                               input logic [3:0]  ws);
        logic [63:0] res;
        int          base;
        res  = old_v;
        base = hi ? 32 : 0;
        for (int b = 0; b < 4; b++) begin
            if (ws[b]) begin
                res[base + 8*b +: 8] = wd[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_aclint_rtc_sync.sv
// Brings the asynchronous rtc into the clk domain and turns each rising
// edge into a one-cycle tick. tick is decoded from two flops of the same
// chain, so it is glitch-free and lands 2 edges after rtc rises.
module iob_aclint_rtc_sync
    import iob_aclint_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rtc,
    output logic tick
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Two-stage synchroniser followed by the edge-detect history flop
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= rtc;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Rising-edge decode of the synchronised rtc
    always_comb begin
        tick = sync2_r & ~prev_r;
    end

endmodule

// File: rtl/iob_aclint.sv
// Core-local interruptor: one shared mtime counter, per-hart MSIP and
// MTIMECMP, per-hart one-shot / auto-reload periodic timer, and a shadowed
// high word so 64-bit mtime can be read tear-free over a 32-bit bus.
module iob_aclint
    import iob_aclint_pkg::*;
#(
    parameter int N_HARTS = 1,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MTIME_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rtc,
    input  logic                 valid,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DATA_W/8-1:0]  wstrb,
    output logic [DATA_W-1:0]    rdata,
    output logic                 ready,
    output logic [N_HARTS-1:0]   mtip,
    output logic [N_HARTS-1:0]   msip
);

    logic                       tick_s;
    logic [31:0]                addr_s;
    logic [31:0]                hart_idx_s;
    reg_sel_e                   reg_sel_s;
    logic                       bus_wr_s;
    logic                       bus_rd_s;
    logic [MTIME_W-1:0]         mtime_r;
    logic [63:0]                mtime64_s;
    logic [31:0]                shadow_r;
    logic [N_HARTS-1:0][31:0]   hart_rd_s;
    logic [31:0]                rd_word_s;
    logic [N_HARTS-1:0]         mtip_nxt_s;
    logic [N_HARTS-1:0]         msip_nxt_s;
    logic [N_HARTS-1:0]         msip_r;
    logic [N_HARTS-1:0]         msip_out_r;
    logic [N_HARTS-1:0]         mtip_r;
    logic                       req_r;
    logic [31:0]                rd_q_r;
    logic                       ready_r;
    logic [DATA_W-1:0]          rdata_r;

    iob_aclint_rtc_sync u_rtc_sync (
        .clk  (clk),
        .rst  (rst),
        .rtc  (rtc),
        .tick (tick_s)
    );

    // Address decode into a register select plus a hart index; hart indices
    // beyond N_HARTS simply match no hart and so read 0 / drop writes.
    always_comb begin
        addr_s     = 32'(address);
        bus_wr_s   = valid && (|wstrb);
        bus_rd_s   = valid && !(|wstrb);
        mtime64_s  = 64'(mtime_r);
        reg_sel_s  = REG_NONE;
        hart_idx_s = 32'd0;
        if (addr_s < MTIMECMP_BASE) begin
            reg_sel_s  = REG_MSIP;
            hart_idx_s = (addr_s - MSIP_BASE) / MSIP_STRIDE;
        end else if (addr_s < CTRL_BASE) begin
            hart_idx_s = (addr_s - MTIMECMP_BASE) / MTIMECMP_STRIDE;
            reg_sel_s  = addr_s[2] ? REG_CMP_HI : REG_CMP_LO;
        end else if (addr_s < MTIME_BASE) begin
            hart_idx_s = (addr_s - CTRL_BASE) / CTRL_STRIDE;
            case (addr_s[3:2])
                CTRL_WORD:      reg_sel_s = REG_CTRL;
                PERIOD_LO_WORD: reg_sel_s = REG_PER_LO;
                PERIOD_HI_WORD: reg_sel_s = REG_PER_HI;
                default:        reg_sel_s = REG_NONE;
            endcase
        end else if (addr_s == MTIME_BASE) begin
            reg_sel_s = REG_MTIME_LO;
        end else if (addr_s == (MTIME_BASE + 32'd4)) begin
            reg_sel_s = REG_MTIME_HI;
        end else begin
            reg_sel_s = REG_NONE;
        end
    end

    for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
        logic [MTIME_W-1:0] cmp_r;
        logic [MTIME_W-1:0] cmp_next_s;
        logic [MTIME_W-1:0] period_r;
        logic [MTIME_W-1:0] period_next_s;
        logic [63:0]        cmp64_s;
        logic [63:0]        period64_s;
        logic               periodic_r;
        logic               periodic_next_s;
        logic               pending_r;
        logic               pending_next_s;
        logic               hit_s;
        logic               wr_s;
        logic               cmp_ge_s;
        logic               pend_set_s;
        logic               pend_clr_s;
        logic               msip_next_s;
        logic               mtip_next_s;
        logic [31:0]        ctrl_word_s;
        logic [31:0]        rd_s;

        // Per-hart compare, auto-reload, PENDING and register next-state;
        // a bus write to MTIMECMP takes priority over the reload, and a
        // PENDING set takes priority over a same-cycle clear.
        always_comb begin
            hit_s       = (hart_idx_s == 32'(h));
            wr_s        = bus_wr_s && hit_s;
            cmp64_s     = 64'(cmp_r);
            period64_s  = 64'(period_r);
            cmp_ge_s    = (mtime_r >= cmp_r);
            pend_set_s  = periodic_r && cmp_ge_s;
            pend_clr_s  = wr_s && (reg_sel_s == REG_CTRL) && wstrb[0]
                          && wdata[CTRL_PENDING_BIT];
            pending_next_s = pend_set_s || (pending_r && !pend_clr_s);
            mtip_next_s = periodic_r ? pending_next_s : cmp_ge_s;

            if (wr_s && (reg_sel_s == REG_CTRL) && wstrb[0]) begin
                periodic_next_s = wdata[CTRL_PERIODIC_BIT];
            end else begin
                periodic_next_s = periodic_r;
            end

            if (wr_s && ((reg_sel_s == REG_CMP_LO) || (reg_sel_s == REG_CMP_HI))) begin
                cmp_next_s = MTIME_W'(write_word(cmp64_s, reg_sel_s == REG_CMP_HI, wdata, wstrb));
            end else if (pend_set_s && (period_r != {MTIME_W{1'b0}})) begin
                cmp_next_s = cmp_r + period_r;
            end else begin
                cmp_next_s = cmp_r;
            end

            if (wr_s && ((reg_sel_s == REG_PER_LO) || (reg_sel_s == REG_PER_HI))) begin
                period_next_s = MTIME_W'(write_word(period64_s, reg_sel_s == REG_PER_HI, wdata, wstrb));
            end else begin
                period_next_s = period_r;
            end

            if (wr_s && (reg_sel_s == REG_MSIP) && wstrb[0]) begin
                msip_next_s = wdata[0];
            end else begin
                msip_next_s = msip_r[h];
            end

            ctrl_word_s = 32'd0;
            ctrl_word_s[CTRL_PERIODIC_BIT] = periodic_r;
            ctrl_word_s[CTRL_PENDING_BIT]  = pending_r;

            if (hit_s) begin
                case (reg_sel_s)
                    REG_MSIP:   rd_s = {31'd0, msip_r[h]};
                    REG_CMP_LO: rd_s = cmp64_s[31:0];
                    REG_CMP_HI: rd_s = cmp64_s[63:32];
                    REG_CTRL:   rd_s = ctrl_word_s;
                    REG_PER_LO: rd_s = period64_s[31:0];
                    REG_PER_HI: rd_s = period64_s[63:32];
                    default:    rd_s = 32'd0;
                endcase
            end else begin
                rd_s = 32'd0;
            end
        end

        // Per-hart timer state registers
        always_ff @(posedge clk) begin
            if (!rst) begin
                cmp_r      <= {MTIME_W{1'b1}};
                period_r   <= {MTIME_W{1'b0}};
                periodic_r <= 1'b0;
                pending_r  <= 1'b0;
            end else begin
                cmp_r      <= cmp_next_s;
                period_r   <= period_next_s;
                periodic_r <= periodic_next_s;
                pending_r  <= pending_next_s;
            end
        end

        assign hart_rd_s[h]  = rd_s;
        assign mtip_nxt_s[h] = mtip_next_s;
        assign msip_nxt_s[h] = msip_next_s;
    end

    // Read mux: per-hart words are zero unless selected, so OR them together
    always_comb begin
        rd_word_s = 32'd0;
        for (int h = 0; h < N_HARTS; h++) begin
            rd_word_s = rd_word_s | hart_rd_s[h];
        end
        if (reg_sel_s == REG_MTIME_LO) begin
            rd_word_s = mtime64_s[31:0];
        end else if (reg_sel_s == REG_MTIME_HI) begin
            rd_word_s = shadow_r;
        end else begin
            rd_word_s = rd_word_s;
        end
    end

    // Shared counter: a bus write beats a same-cycle tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_r <= {MTIME_W{1'b0}};
        end else if (bus_wr_s && (reg_sel_s == REG_MTIME_LO)) begin
            mtime_r <= MTIME_W'(write_word(mtime64_s, 1'b0, wdata, wstrb));
        end else if (bus_wr_s && (reg_sel_s == REG_MTIME_HI)) begin
            mtime_r <= MTIME_W'(write_word(mtime64_s, 1'b1, wdata, wstrb));
        end else if (tick_s) begin
            mtime_r <= mtime_r + {{(MTIME_W-1){1'b0}}, 1'b1};
        end else begin
            mtime_r <= mtime_r;
        end
    end

    // High-word shadow captured when the low word is read
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_r <= 32'd0;
        end else if (bus_rd_s && (reg_sel_s == REG_MTIME_LO)) begin
            shadow_r <= mtime64_s[63:32];
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Interrupt state and registered interrupt outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            msip_r     <= {N_HARTS{1'b0}};
            msip_out_r <= {N_HARTS{1'b0}};
            mtip_r     <= {N_HARTS{1'b0}};
        end else begin
            msip_r     <= msip_nxt_s;
            msip_out_r <= msip_r;
            mtip_r     <= mtip_nxt_s;
        end
    end

    // Two-stage response: read data captured at the request edge, then
    // presented with ready one edge later; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_r   <= 1'b0;
            rd_q_r  <= 32'd0;
            ready_r <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            req_r   <= valid;
            rd_q_r  <= rd_word_s;
            ready_r <= req_r;
            rdata_r <= req_r ? DATA_W'(rd_q_r) : {DATA_W{1'b0}};
        end
    end

    assign rdata = rdata_r;
    assign ready = ready_r;
    assign mtip  = mtip_r;
    assign msip  = msip_out_r;

endmodule
